mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the shared byte-wide memory. Requester 0 is the CPU and requester 1 is the wasm loader/ROM mapper. It grants the single memory port round-robin and drives the memory's read/write/ready handshake. It keeps a one-entry read shadow so that a repeated read of the last-read address still completes: the memory ignores a read whose address equals its last read address.

## Interface
- `TIMEOUT_CYCLES`, default 16: `READ_WAIT` cycles without `mem_ready` before timeout. Used only with the timeout feature.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rN_addr` in 32: requester N address, N=0,1.
- `rN_wdata` in 8: requester N write data.
- `rN_read_en` / `rN_write_en` in 1: level request, held until `rN_ready`.
- `rN_rdata` out 8: read data, valid while `rN_ready`=1.
- `rN_ready` out 1: one-cycle completion pulse.
- `mem_addr` out 32, `mem_data_in` out 8, `memory_read_en` out 1, `memory_write_en` out 1: memory side, all registered.
- `mem_data_out` in 8, `mem_ready` in 1: memory read data and read-done pulse.
- `grant_id` out 1: last granted requester.
- `err` out 1: timeout pulse, coincident with `rN_ready`.

## Operation
- FSM states: `IDLE`, `WRITE`, `READ_WAIT`, `RESP`.
- `IDLE`:
  - Arbitrate among requesters with `read_en|write_en` high. If both request, grant the one not equal to `grant_id` (round-robin).
  - Latch the winner's addr/wdata/op.
  - Write → `WRITE`.
  - Read with shadow hit (`shadow_valid && addr==shadow_addr`) → `RESP`, with rdata = `shadow_data`.
  - Read with shadow miss → `READ_WAIT`.
- A requester asserting both enables is treated as a write.
- `WRITE`: `memory_write_en`=1 for exactly one cycle; clear `shadow_valid`; → `RESP`.
- `READ_WAIT`: hold `memory_read_en`=1 with the addr. On `mem_ready`, capture `mem_data_out` into rdata and the shadow, set `shadow_valid`/`shadow_addr`, → `RESP`.
- `RESP`:
  - Pulse the granted `rN_ready` with rdata. rdata is unchanged on a write ack.
  - Memory enables are 0.
  - → `IDLE`.
- Requests are not sampled during `RESP`. Requesters must drop or change their request in the cycle after their ack.
- Any write, to any address, invalidates the shadow. This mirrors the memory, which clears its last-address record on every write.
- Address arithmetic: full 32-bit compare for shadow hit; no masking in the arbiter.

## Timing
- Request first seen in `IDLE` in cycle N.
- Write: `memory_write_en` in N+1, ack in N+2.
- Read miss: `memory_read_en` from N+1; `mem_ready` in N+2; ack in N+3 with data. Latency grows by one cycle for each extra cycle `mem_ready` is late.
- Read hit: ack in N+1 with no memory access.
- Ungranted requester waits at least one full transaction. Fairness: with both requesting continuously, grants alternate.
- Reset values: state `IDLE`; all memory-side outputs 0; `rN_ready`=0; `rN_rdata`=0; `err`=0; `grant_id`=1, so requester 0 wins the first tie; `shadow_valid`=0.
- Reset mid-transaction: abort immediately with no ack. A write in flight is dropped if `rst` rises before its `WRITE` cycle edge.
- Hazard: the memory has no reset and keeps its last read address. A post-reset read of that address never sees `mem_ready` unless the timeout is compiled in.

## Configuration
- `MEM_ARBITER_TIMEOUT_EN` defined:
  - A counter runs in `READ_WAIT`.
  - After `TIMEOUT_CYCLES` cycles without `mem_ready` → `RESP` with rdata=8'hFF and `err`=1 for the ack cycle.
  - Shadow is not updated.
- Undefined: `READ_WAIT` waits indefinitely; `err` is tied to 0; no counter logic.

## Structure
- Package `mem_arbiter_pkg` holds:
  - the FSM state enum;
  - requester-id constants `REQ_CPU`=0 and `REQ_WASM`=1;
  - `ERR_DATA`=8'hFF;
  - the default `TIMEOUT_CYCLES`.
- One sub-module, `mem_arbiter_rr`: a combinational/registered 2-way round-robin picker that outputs grant and valid.

## Test plan
- r0 writes 8'h1E to 0xAB → `memory_write_en` for one cycle with `mem_addr`=0xAB and `mem_data_in`=0x1E; `r0_ready` 2 cycles after request. A subsequent r0 read of 0xAB returns 8'h1E in 3 cycles.
- r1 reads 0x1A twice back-to-back → first read goes to memory (3-cycle ack); second is a shadow hit, 1-cycle ack, with no `memory_read_en` pulse.
- r0 and r1 read different addresses simultaneously, continuously → grants alternate 0,1,0,1 starting with r0; each sees correct data.
- Shadow hit on 0x5A, then r0 writes 0x5A=8'h77, then r1 reads 0x5A → read goes to memory and returns 8'h77.
- With `MEM_ARBITER_TIMEOUT_EN`: memory model holds `mem_ready`=0 → ack after 16 wait cycles with rdata=8'hFF and `err`=1. Without the macro, no ack is ever produced.
- Assert `rst` during `READ_WAIT` → all outputs 0 in the same cycle, no ack, FSM in `IDLE`; next request is serviced normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic       REQ_CPU  = 1'b0;
    localparam logic       REQ_WASM = 1'b1;
    localparam logic [7:0] ERR_DATA = 8'hFF;
    localparam int         TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker: on a tie the requester that did not win last time gets the grant.
module mem_arbiter_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        if (&req_i) begin
            grant_o = ~last_i;
        end else begin
            grant_o = req_i[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared byte-wide memory with a one-entry read shadow.
// Optional read timeout is compiled in with MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] r0_addr,
    input  logic [7:0]  r0_wdata,
    input  logic        r0_read_en,
    input  logic        r0_write_en,
    output logic [7:0]  r0_rdata,
    output logic        r0_ready,
    input  logic [31:0] r1_addr,
    input  logic [7:0]  r1_wdata,
    input  logic        r1_read_en,
    input  logic        r1_write_en,
    output logic [7:0]  r1_rdata,
    output logic        r1_ready,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in,
    output logic        memory_read_en,
    output logic        memory_write_en,
    input  logic [7:0]  mem_data_out,
    input  logic        mem_ready,
    output logic        grant_id,
    output logic        err
);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_data_in_q, mem_data_in_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        shadow_valid_q, shadow_valid_d;
    logic [31:0] shadow_addr_q, shadow_addr_d;
    logic [7:0]  shadow_data_q, shadow_data_d;

    logic        pick;
    logic        pick_valid;
    logic [31:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_write;

    mem_arbiter_rr u_rr (
        .req_i   ({r1_read_en | r1_write_en, r0_read_en | r0_write_en}),
        .last_i  (grant_q),
        .grant_o (pick),
        .valid_o (pick_valid)
    );

    // Write enable dominates when a requester raises both enables.
    assign sel_addr  = pick ? r1_addr     : r0_addr;
    assign sel_wdata = pick ? r1_wdata    : r0_wdata;
    assign sel_write = pick ? r1_write_en : r0_write_en;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        mem_addr_d     = mem_addr_q;
        mem_data_in_d  = mem_data_in_q;
        mem_rd_d       = mem_rd_q;
        mem_wr_d       = 1'b0;
        rdata_d        = rdata_q;
        shadow_valid_d = shadow_valid_q;
        shadow_addr_d  = shadow_addr_q;
        shadow_data_d  = shadow_data_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
        cnt_d          = cnt_q;
        err_d          = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d       = pick;
                    mem_addr_d    = sel_addr;
                    mem_data_in_d = sel_wdata;
                    if (sel_write) begin
                        mem_wr_d = 1'b1;
                        state_d  = WRITE;
                    end else if (shadow_valid_q && (sel_addr == shadow_addr_q)) begin
                        rdata_d = shadow_data_q;
                        state_d = RESP;
                    end else begin
                        mem_rd_d = 1'b1;
                        state_d  = READ_WAIT;
`ifdef MEM_ARBITER_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end
            WRITE: begin
                // The memory forgets its last read address on any write, so the shadow must too.
                shadow_valid_d = 1'b0;
                state_d        = RESP;
            end
            READ_WAIT: begin
                if (mem_ready) begin
                    rdata_d        = mem_data_out;
                    shadow_valid_d = 1'b1;
                    shadow_addr_d  = mem_addr_q;
                    shadow_data_d  = mem_data_out;
                    mem_rd_d       = 1'b0;
                    state_d        = RESP;
                end
`ifdef MEM_ARBITER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d  = ERR_DATA;
                    err_d    = 1'b1;
                    mem_rd_d = 1'b0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_q        <= REQ_WASM;
            mem_addr_q     <= '0;
            mem_data_in_q  <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            rdata_q        <= '0;
            shadow_valid_q <= 1'b0;
            shadow_addr_q  <= '0;
            shadow_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_in_q  <= mem_data_in_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            rdata_q        <= rdata_d;
            shadow_valid_q <= shadow_valid_d;
            shadow_addr_q  <= shadow_addr_d;
            shadow_data_q  <= shadow_data_d;
        end
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign r0_ready        = (state_q == RESP) && (grant_q == REQ_CPU);
    assign r1_ready        = (state_q == RESP) && (grant_q == REQ_WASM);
    assign r0_rdata        = rdata_q;
    assign r1_rdata        = rdata_q;
    assign mem_addr        = mem_addr_q;
    assign mem_data_in     = mem_data_in_q;
    assign memory_read_en  = mem_rd_q;
    assign memory_write_en = mem_wr_q;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small memory model that ignores repeated reads of its last read address.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] r0_addr = '0, r1_addr = '0;
    logic [7:0]  r0_wdata = '0, r1_wdata = '0;
    logic        r0_read_en = 1'b0, r0_write_en = 1'b0;
    logic        r1_read_en = 1'b0, r1_write_en = 1'b0;
    logic [7:0]  r0_rdata, r1_rdata;
    logic        r0_ready, r1_ready;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in;
    logic        memory_read_en, memory_write_en;
    logic [7:0]  mem_data_out = '0;
    logic        mem_ready = 1'b0;
    logic        grant_id, err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_read_en(r0_read_en), .r0_write_en(r0_write_en),
        .r0_rdata(r0_rdata), .r0_ready(r0_ready),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_read_en(r1_read_en), .r1_write_en(r1_write_en),
        .r1_rdata(r1_rdata), .r1_ready(r1_ready),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .memory_read_en(memory_read_en), .memory_write_en(memory_write_en),
        .mem_data_out(mem_data_out), .mem_ready(mem_ready),
        .grant_id(grant_id), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: no reset, remembers its last read address, optional stall.
    logic [7:0]  mem_arr [256];
    logic [31:0] last_rd_addr  = '0;
    logic        last_rd_valid = 1'b0;
    logic        mem_stall     = 1'b0;

    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (memory_write_en) begin
            mem_arr[mem_addr[7:0]] <= mem_data_in;
            last_rd_valid          <= 1'b0;
        end else if (memory_read_en && !mem_stall && !mem_ready &&
                     !(last_rd_valid && last_rd_addr == mem_addr)) begin
            mem_ready     <= 1'b1;
            mem_data_out  <= mem_arr[mem_addr[7:0]];
            last_rd_valid <= 1'b1;
            last_rd_addr  <= mem_addr;
        end
    end

    // Activity monitor sampled on the falling edge.
    int          wr_cycles = 0;
    int          rd_pulses = 0;
    int          ack_cnt   = 0;
    logic        rd_prev   = 1'b0;
    logic [31:0] w_addr    = '0;
    logic [7:0]  w_data    = '0;

    always @(negedge clk) begin
        if (memory_write_en) begin
            wr_cycles <= wr_cycles + 1;
            w_addr    <= mem_addr;
            w_data    <= mem_data_in;
        end
        if (memory_read_en && !rd_prev) rd_pulses <= rd_pulses + 1;
        rd_prev <= memory_read_en;
        if (r0_ready || r1_ready) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at posedge+1 (cycle N); lat is the ack cycle offset, 0 if none within bound.
    task automatic do_req(input bit id, input bit wr, input logic [31:0] a, input logic [7:0] wd,
                          input int bound, output int lat, output logic [7:0] rd, output logic e);
        lat = 0;
        rd  = 'x;
        e   = 1'bx;
        if (id) begin
            r1_addr = a; r1_wdata = wd; r1_write_en = wr; r1_read_en = !wr;
        end else begin
            r0_addr = a; r0_wdata = wd; r0_write_en = wr; r0_read_en = !wr;
        end
        for (int c = 1; c <= bound; c++) begin
            @(posedge clk); #1;
            if (id ? r1_ready : r0_ready) begin
                lat = c;
                rd  = id ? r1_rdata : r0_rdata;
                e   = err;
                break;
            end
        end
        r0_read_en = 1'b0; r0_write_en = 1'b0;
        r1_read_en = 1'b0; r1_write_en = 1'b0;
        $display("txn r%0d %s addr=%08h wdata=%02h lat=%0d rdata=%02h err=%b",
                 id, wr ? "wr" : "rd", a, wd, lat, rd, e);
        if (lat != 0) begin
            @(posedge clk); #1;
        end
    endtask

    int          lat;
    logic [7:0]  rd;
    logic        e;
    int          base_rd, base_wr, base_ack;
    int          n;
    logic [3:0]  order;
    logic [7:0]  pre_addr [4];
    logic [7:0]  pre_data [4];

    initial begin
        pre_addr[0] = 8'h1A; pre_data[0] = 8'h3C;
        pre_addr[1] = 8'h10; pre_data[1] = 8'h11;
        pre_addr[2] = 8'h20; pre_data[2] = 8'h22;
        pre_addr[3] = 8'h5A; pre_data[3] = 8'h99;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", {31'd0, memory_read_en}, 32'd0);
        chk("rst_wr_en", {31'd0, memory_write_en}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
        chk("rst_rdata", {24'd0, r0_rdata}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_grant", {31'd0, grant_id}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // r0 write 0xAB then read it back
        base_wr = wr_cycles;
        do_req(1'b0, 1'b1, 32'hAB, 8'h1E, 20, lat, rd, e);
        chk("wr_lat", lat, 2);
        chk("wr_cycles", wr_cycles - base_wr, 1);
        chk("wr_addr", w_addr, 32'hAB);
        chk("wr_data", {24'd0, w_data}, 32'h1E);
        do_req(1'b0, 1'b0, 32'hAB, 8'h00, 20, lat, rd, e);
        chk("rdback_lat", lat, 3);
        chk("rdback_data", {24'd0, rd}, 32'h1E);
        chk("rdback_err", {31'd0, e}, 32'd0);

        // Preload through the arbiter, alternating requesters
        for (int i = 0; i < 4; i++) begin
            do_req(i[0], 1'b1, {24'd0, pre_addr[i]}, pre_data[i], 20, lat, rd, e);
            chk("pre_lat", lat, 2);
        end

        // r1 reads 0x1A twice: miss then shadow hit
        base_rd = rd_pulses;
        do_req(1'b1, 1'b0, 32'h1A, 8'h00, 20, lat, rd, e);
        chk("miss_lat", lat, 3);
        chk("miss_data", {24'd0, rd}, 32'h3C);
        do_req(1'b1, 1'b0, 32'h1A, 8'h00, 20, lat, rd, e);
        chk("hit_lat", lat, 1);
        chk("hit_data", {24'd0, rd}, 32'h3C);
        chk("hit_no_mem", rd_pulses - base_rd, 1);

        // Shadow invalidation by a write to the same address
        do_req(1'b1, 1'b0, 32'h5A, 8'h00, 20, lat, rd, e);
        chk("s5a_miss_data", {24'd0, rd}, 32'h99);
        do_req(1'b1, 1'b0, 32'h5A, 8'h00, 20, lat, rd, e);
        chk("s5a_hit_lat", lat, 1);
        do_req(1'b0, 1'b1, 32'h5A, 8'h77, 20, lat, rd, e);
        chk("s5a_wr_lat", lat, 2);
        base_rd = rd_pulses;
        do_req(1'b1, 1'b0, 32'h5A, 8'h00, 20, lat, rd, e);
        chk("s5a_inval_lat", lat, 3);
        chk("s5a_inval_data", {24'd0, rd}, 32'h77);
        chk("s5a_inval_mem", rd_pulses - base_rd, 1);

        // Both requesters reading continuously: grants alternate starting with r0
        r0_addr = 32'h10; r0_read_en = 1'b1;
        r1_addr = 32'h20; r1_read_en = 1'b1;
        n = 0;
        order = '0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(posedge clk); #1;
            if (r0_ready) begin
                order[n] = 1'b0;
                chk("alt_r0_data", {24'd0, r0_rdata}, 32'h11);
                $display("txn alt r0 rdata=%02h", r0_rdata);
                n++;
            end else if (r1_ready) begin
                order[n] = 1'b1;
                chk("alt_r1_data", {24'd0, r1_rdata}, 32'h22);
                $display("txn alt r1 rdata=%02h", r1_rdata);
                n++;
            end
        end
        r0_read_en = 1'b0; r1_read_en = 1'b0;
        chk("alt_count", n, 4);
        chk("alt_order", {28'd0, order}, 32'b1010);
        @(posedge clk); #1;

        // Stalled memory: timeout ack or indefinite wait
        mem_stall = 1'b1;
        base_ack  = ack_cnt;
`ifdef MEM_ARBITER_TIMEOUT_EN
        do_req(1'b0, 1'b0, 32'h33, 8'h00, 40, lat, rd, e);
        chk("to_lat", lat, 17);
        chk("to_data", {24'd0, rd}, 32'hFF);
        chk("to_err", {31'd0, e}, 32'd1);
        r0_addr = 32'h44; r0_read_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        r0_read_en = 1'b0;
        base_ack = ack_cnt;
`else
        do_req(1'b0, 1'b0, 32'h33, 8'h00, 40, lat, rd, e);
        chk("noto_no_ack", lat, 0);
        chk("noto_ack_cnt", ack_cnt - base_ack, 0);
`endif
        chk("pre_rst_state", {30'd0, dut.state_q}, {30'd0, READ_WAIT});

        // Asynchronous reset in READ_WAIT
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_en", {31'd0, memory_read_en}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
        chk("arst_rdata", {24'd0, r0_rdata}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        chk("arst_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_stall = 1'b0;
        chk("arst_no_ack", ack_cnt - base_ack, 0);
        @(posedge clk); #1;
        do_req(1'b0, 1'b0, 32'h10, 8'h00, 20, lat, rd, e);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", {24'd0, rd}, 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
